alu_pipe_fu: RTL and testbench

- Parametrised, pipelined integer ALU functional unit for the o3cpu back end.
- Sits between the ALU reservation station (issue side) and the common data bus (CDB) arbiter (writeback side).
- Accepts one operation per cycle with a valid/ready handshake and carries the ROB destination tag through a configurable pipeline.
- Presents the result, zero and overflow flags to the CDB with backpressure. Supports a pipeline flush on branch mispredict.

---
 rtl/alu_pipe_fu_pkg.sv | 35 +++
 rtl/alu_pipe_fu_core.sv | 57 +++++
 rtl/alu_pipe_fu.sv | 106 ++++++++++
 tb/tb_alu_pipe_fu.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pipe_fu_pkg.sv
// Shared definitions for the o3cpu integer ALU functional unit: opcodes,
// default widths and the overflow rules used by the compute core.
package alu_pipe_fu_pkg;

  localparam int XLEN_DEFAULT = 32;
  localparam int ROB_ENTRY_W  = 4;
  localparam int ALU_OP_W     = 4;

  typedef enum logic [ALU_OP_W-1:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SLT  = 4'd7,
    ALU_SLTU = 4'd8,
    ALU_SRA  = 4'd9,
    ALU_AP4  = 4'd10,
    ALU_OUTB = 4'd11
  } alu_op_e;

  // Two's-complement overflow from the sign bits of a, b and the result.
  function automatic logic add_ovf(input logic sign_a, input logic sign_b,
                                   input logic sign_r);
    return (sign_a == sign_b) && (sign_r != sign_a);
  endfunction

  function automatic logic sub_ovf(input logic sign_a, input logic sign_b,
                                   input logic sign_r);
    return (sign_a != sign_b) && (sign_r != sign_a);
  endfunction

endpackage

// File: rtl/alu_pipe_fu_core.sv
// Combinational ALU datapath feeding stage 0: result, zero and signed
// overflow for one operation.
module alu_pipe_core
  import alu_pipe_fu_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT,
  parameter int OP_W = ALU_OP_W
) (
  input  logic [OP_W-1:0] op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] res,
  output logic            zero,
  output logic            ovf
);

  localparam int SH_W = $clog2(XLEN);
  localparam logic [XLEN-1:0] FOUR = XLEN'(4);

  logic [SH_W-1:0] shamt;
  assign shamt = b[SH_W-1:0];

  // NOTE: combinational blocks use blocking '=' so the overflow terms below can
  // read the freshly computed res; every output gets a default first so no
  // latch is inferred for opcodes that do not assign it.
  always_comb begin
    res = '0;
    ovf = 1'b0;
    case (op)
      OP_W'(ALU_ADD): begin
        res = a + b;
        ovf = add_ovf(a[XLEN-1], b[XLEN-1], res[XLEN-1]);
      end
      OP_W'(ALU_SUB): begin
        res = a - b;
        ovf = sub_ovf(a[XLEN-1], b[XLEN-1], res[XLEN-1]);
      end
      OP_W'(ALU_AP4): begin
        res = a + FOUR;
        ovf = add_ovf(a[XLEN-1], FOUR[XLEN-1], res[XLEN-1]);
      end
      OP_W'(ALU_AND):  res = a & b;
      OP_W'(ALU_OR):   res = a | b;
      OP_W'(ALU_XOR):  res = a ^ b;
      OP_W'(ALU_SLL):  res = a << shamt;
      OP_W'(ALU_SRL):  res = a >> shamt;
      OP_W'(ALU_SRA):  res = $signed(a) >>> shamt;
      OP_W'(ALU_SLT):  res = XLEN'($signed(a) < $signed(b));
      OP_W'(ALU_SLTU): res = XLEN'(a < b);
      OP_W'(ALU_OUTB): res = b;
      default:         res = '0;
    endcase
  end

  assign zero = ~|res;

endmodule

// File: rtl/alu_pipe_fu.sv
// Pipelined ALU functional unit: issue handshake, STAGES result registers
// with collapsing bubbles, CDB backpressure and mispredict flush.
module alu_pipe_fu
  import alu_pipe_fu_pkg::*;
#(
  parameter int XLEN   = XLEN_DEFAULT,
  parameter int STAGES = 2,
  parameter int ROB_W  = ROB_ENTRY_W,
  parameter int OP_W   = ALU_OP_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  in_op,
  input  logic [XLEN-1:0]  in_a,
  input  logic [XLEN-1:0]  in_b,
  input  logic [ROB_W-1:0] in_dest,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_res,
  output logic [ROB_W-1:0] out_dest,
  output logic             out_zero,
  output logic             out_ovf,
  output logic             busy
);

  typedef struct packed {
    logic             valid;
    logic [XLEN-1:0]  res;
    logic [ROB_W-1:0] dest;
    logic             zero;
    logic             ovf;
  } stage_t;

  stage_t              stg [STAGES];
  stage_t              s0_next;
  logic [STAGES-1:0]   can_load;
  logic [XLEN-1:0]     core_res;
  logic                core_zero;
  logic                core_ovf;

  alu_pipe_core #(
    .XLEN (XLEN),
    .OP_W (OP_W)
  ) u_core (
    .op   (in_op),
    .a    (in_a),
    .b    (in_b),
    .res  (core_res),
    .zero (core_zero),
    .ovf  (core_ovf)
  );

  always_comb begin
    s0_next.valid = in_valid;
    s0_next.res   = core_res;
    s0_next.dest  = in_dest;
    s0_next.zero  = core_zero;
    s0_next.ovf   = core_ovf;
  end

  // A stage can take new contents when it is empty or its occupant moves on;
  // walking from the CDB end backwards lets bubbles collapse in one cycle.
  always_comb begin
    logic downstream_free;
    can_load        = '0;
    downstream_free = !stg[STAGES-1].valid || out_ready;
    can_load[STAGES-1] = downstream_free;
    for (int i = STAGES - 2; i >= 0; i--) begin
      downstream_free = !stg[i].valid || downstream_free;
      can_load[i]     = downstream_free;
    end
  end

  assign in_ready = can_load[0];

  // NOTE: reset clears the data fields as well as the valid bits because the
  // last stage drives out_* directly and those must read zero after reset;
  // flush only needs the valid bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) stg[i] <= '0;
    end else if (flush) begin
      for (int i = 0; i < STAGES; i++) stg[i].valid <= 1'b0;
    end else begin
      if (can_load[0]) stg[0] <= s0_next;
      for (int i = 1; i < STAGES; i++) begin
        if (can_load[i]) stg[i] <= stg[i-1];
      end
    end
  end

  assign out_valid = stg[STAGES-1].valid;
  assign out_res   = stg[STAGES-1].res;
  assign out_dest  = stg[STAGES-1].dest;
  assign out_zero  = stg[STAGES-1].zero;
  assign out_ovf   = stg[STAGES-1].ovf;

  always_comb begin
    busy = 1'b0;
    for (int i = 0; i < STAGES; i++) busy = busy | stg[i].valid;
  end

endmodule

// File: tb/tb_alu_pipe_fu.sv
// Directed, table-driven bench for alu_pipe_fu: a 32-bit 2-stage instance and
// a 64-bit 3-stage instance share stimulus; sel64 picks which one is scored.
module tb_alu_pipe_fu;
  import alu_pipe_fu_pkg::*;

  typedef struct {
    logic [3:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic [3:0]  dest;
    logic [63:0] res;
    logic        zero;
    logic        ovf;
  } vec_t;

  typedef struct {
    logic [63:0] res;
    logic [3:0]  dest;
    logic        zero;
    logic        ovf;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready, sel64;
  logic [3:0]  in_op, in_dest;
  logic [63:0] in_a, in_b;

  logic        in_valid32, in_ready32, out_valid32, out_zero32, out_ovf32, busy32;
  logic [31:0] out_res32;
  logic [3:0]  out_dest32;
  logic        in_valid64, in_ready64, out_valid64, out_zero64, out_ovf64, busy64;
  logic [63:0] out_res64;
  logic [3:0]  out_dest64;

  logic        o_valid, o_in_ready, o_zero, o_ovf, o_busy;
  logic [63:0] o_res;
  logic [3:0]  o_dest;

  int   n_checks = 0;
  int   n_fail   = 0;
  vec_t cur [$];
  exp_t sb  [$];

  always #5 clk = ~clk;

  assign in_valid32 = in_valid & ~sel64;
  assign in_valid64 = in_valid & sel64;

  alu_pipe_fu #(.XLEN(32), .STAGES(2), .ROB_W(4), .OP_W(4)) dut32 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid32), .in_ready(in_ready32), .in_op(in_op),
    .in_a(in_a[31:0]), .in_b(in_b[31:0]), .in_dest(in_dest),
    .out_valid(out_valid32), .out_ready(out_ready), .out_res(out_res32),
    .out_dest(out_dest32), .out_zero(out_zero32), .out_ovf(out_ovf32),
    .busy(busy32)
  );

  alu_pipe_fu #(.XLEN(64), .STAGES(3), .ROB_W(4), .OP_W(4)) dut64 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid64), .in_ready(in_ready64), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .in_dest(in_dest),
    .out_valid(out_valid64), .out_ready(out_ready), .out_res(out_res64),
    .out_dest(out_dest64), .out_zero(out_zero64), .out_ovf(out_ovf64),
    .busy(busy64)
  );

  assign o_valid    = sel64 ? out_valid64 : out_valid32;
  assign o_in_ready = sel64 ? in_ready64  : in_ready32;
  assign o_res      = sel64 ? out_res64   : {32'h0, out_res32};
  assign o_dest     = sel64 ? out_dest64  : out_dest32;
  assign o_zero     = sel64 ? out_zero64  : out_zero32;
  assign o_ovf      = sel64 ? out_ovf64   : out_ovf32;
  assign o_busy     = sel64 ? busy64      : busy32;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic [3:0] op, input logic [63:0] a,
                              input logic [63:0] b, input logic [3:0] dest,
                              input logic [63:0] res, input logic zero,
                              input logic ovf);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.dest = dest;
    v.res = res; v.zero = zero; v.ovf = ovf;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    in_valid = 1'b1;
    in_op    = v.op;
    in_a     = v.a;
    in_b     = v.b;
    in_dest  = v.dest;
  endtask

  task automatic compare(input string tag, input exp_t e);
    check({tag, "_res"},  o_res,  e.res);
    check({tag, "_dest"}, o_dest, {60'h0, e.dest});
    check({tag, "_zero"}, o_zero, {63'h0, e.zero});
    check({tag, "_ovf"},  o_ovf,  {63'h0, e.ovf});
  endtask

  // Streams cur[start..] with out_ready=1, scoring every CDB handshake against
  // the in-order expectation queue; optionally checks latency and no gaps.
  task automatic stream(input string tag, input int start, input bit timing,
                        input int lat);
    int   idx  = start;
    int   cyc  = 0;
    int   last = -1;
    exp_t e;
    out_ready = 1'b1;
    while ((idx < cur.size() || sb.size() > 0) && cyc < 200) begin
      if (idx < cur.size()) drive(cur[idx]);
      else in_valid = 1'b0;
      #1;
      if (o_valid) begin
        if (sb.size() == 0) begin
          check({tag, "_spurious_out"}, {63'h0, o_valid}, 64'h0);
        end else begin
          e = sb.pop_front();
          compare(tag, e);
          if (timing) begin
            if (last < 0) check({tag, "_latency"}, 64'(cyc), 64'(lat));
            else          check({tag, "_gap"}, 64'(cyc - last), 64'd1);
          end
          last = cyc;
        end
      end
      if (in_valid && o_in_ready) begin
        e.res = cur[idx].res; e.dest = cur[idx].dest;
        e.zero = cur[idx].zero; e.ovf = cur[idx].ovf;
        sb.push_back(e);
        idx++;
      end
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    check({tag, "_complete"}, 64'(sb.size() + (cur.size() - idx)), 64'h0);
    sb.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int   acc;
    int   leak;

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; sel64 = 1'b0;
    in_op = '0; in_a = '0; in_b = '0; in_dest = '0;
    tick(); tick();
    check("rst_out_valid", {63'h0, o_valid}, 64'h0);
    check("rst_out_res",   o_res, 64'h0);
    check("rst_out_dest",  {60'h0, o_dest}, 64'h0);
    check("rst_busy",      {63'h0, o_busy}, 64'h0);
    rst = 1'b0;
    #1;
    check("rst_in_ready",  {63'h0, o_in_ready}, 64'h1);

    // Single ADD overflow: visible exactly two cycles after accept.
    out_ready = 1'b1;
    drive(mk(ALU_ADD, 64'h7FFF_FFFF, 64'h1, 4'd3, 64'h8000_0000, 1'b0, 1'b1));
    #1;
    check("add_in_ready", {63'h0, o_in_ready}, 64'h1);
    tick();
    in_valid = 1'b0;
    check("add_cyc1_valid", {63'h0, o_valid}, 64'h0);
    tick();
    check("add_cyc2_valid", {63'h0, o_valid}, 64'h1);
    e.res = 64'h8000_0000; e.dest = 4'd3; e.zero = 1'b0; e.ovf = 1'b1;
    compare("add_ovf", e);
    tick();
    check("add_drained_valid", {63'h0, o_valid}, 64'h0);
    check("add_drained_busy",  {63'h0, o_busy}, 64'h0);

    // 32-bit table, issued back to back.
    cur.delete();
    cur.push_back(mk(ALU_SUB,  64'h5,         64'h5,         4'd1, 64'h0,         1, 0));
    cur.push_back(mk(ALU_SRA,  64'h8000_0000, 64'h4,         4'd2, 64'hF800_0000, 0, 0));
    cur.push_back(mk(ALU_SLTU, 64'h1,         64'hFFFF_FFFF, 4'd3, 64'h1,         0, 0));
    cur.push_back(mk(ALU_SLT,  64'h1,         64'hFFFF_FFFF, 4'd4, 64'h0,         1, 0));
    cur.push_back(mk(ALU_SLT,  64'hFFFF_FFFF, 64'h1,         4'd5, 64'h1,         0, 0));
    cur.push_back(mk(ALU_SUB,  64'h8000_0000, 64'h1,         4'd6, 64'h7FFF_FFFF, 0, 1));
    cur.push_back(mk(ALU_AND,  64'hF0F0_F0F0, 64'hFF00_FF00, 4'd7, 64'hF000_F000, 0, 0));
    cur.push_back(mk(ALU_OR,   64'h0F00_0000, 64'h0000_00F0, 4'd8, 64'h0F00_00F0, 0, 0));
    cur.push_back(mk(ALU_XOR,  64'hFFFF_FFFF, 64'hFFFF_FFFF, 4'd9, 64'h0,         1, 0));
    cur.push_back(mk(ALU_SLL,  64'h1,         64'h3F,        4'd10, 64'h8000_0000, 0, 0));
    cur.push_back(mk(ALU_SRL,  64'h8000_0000, 64'h21,        4'd11, 64'h4000_0000, 0, 0));
    cur.push_back(mk(ALU_SRL,  64'hDEAD_BEEF, 64'h20,        4'd12, 64'hDEAD_BEEF, 0, 0));
    cur.push_back(mk(ALU_AP4,  64'h7FFF_FFFC, 64'h0,         4'd13, 64'h8000_0000, 0, 1));
    cur.push_back(mk(ALU_OUTB, 64'h123,       64'hDEAD_BEEF, 4'd14, 64'hDEAD_BEEF, 0, 0));
    cur.push_back(mk(4'd15,    64'h5,         64'h6,         4'd15, 64'h0,         1, 0));
    cur.push_back(mk(ALU_ADD,  64'hFFFF_FFFF, 64'h1,         4'd0, 64'h0,         1, 0));
    stream("t32", 0, 1'b1, 2);

    // Backpressure: only STAGES ops fit, outputs hold, then drain in order.
    cur.delete();
    for (int i = 0; i < 4; i++)
      cur.push_back(mk(ALU_ADD, 64'(i), 64'd10, 4'(8 + i), 64'(10 + i), 0, 0));
    out_ready = 1'b0;
    acc = 0;
    repeat (6) begin
      drive(cur[acc]);
      #1;
      if (o_in_ready) begin
        e.res = cur[acc].res; e.dest = cur[acc].dest;
        e.zero = cur[acc].zero; e.ovf = cur[acc].ovf;
        sb.push_back(e);
        acc++;
      end
      tick();
    end
    check("stall_accepted", 64'(acc), 64'd2);
    check("stall_in_ready", {63'h0, o_in_ready}, 64'h0);
    check("stall_valid",    {63'h0, o_valid}, 64'h1);
    repeat (3) tick();
    check("stall_hold_res",  o_res, 64'd10);
    check("stall_hold_dest", {60'h0, o_dest}, 64'd8);
    stream("drain", acc, 1'b0, 0);

    // Flush with two ops in flight and a simultaneous issue.
    out_ready = 1'b0;
    drive(mk(ALU_ADD, 64'h1, 64'h1, 4'd12, 64'h2, 0, 0));
    #1;
    check("flush_pre_ready0", {63'h0, o_in_ready}, 64'h1);
    tick();
    drive(mk(ALU_ADD, 64'h2, 64'h2, 4'd13, 64'h4, 0, 0));
    #1;
    check("flush_pre_ready1", {63'h0, o_in_ready}, 64'h1);
    tick();
    check("flush_pre_busy", {63'h0, o_busy}, 64'h1);
    flush = 1'b1;
    drive(mk(ALU_ADD, 64'h3, 64'h3, 4'd14, 64'h6, 0, 0));
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    check("flush_busy",      {63'h0, o_busy}, 64'h0);
    check("flush_out_valid", {63'h0, o_valid}, 64'h0);
    check("flush_in_ready",  {63'h0, o_in_ready}, 64'h1);
    out_ready = 1'b1;
    leak = 0;
    repeat (6) begin
      tick();
      if (o_valid) leak++;
    end
    check("flush_leak", 64'(leak), 64'h0);

    // Reset while a result is stalled at the output.
    out_ready = 1'b0;
    drive(mk(ALU_ADD, 64'h1, 64'h1, 4'd9, 64'h2, 0, 0));
    tick();
    in_valid = 1'b0;
    tick();
    check("mrst_pre_valid", {63'h0, o_valid}, 64'h1);
    check("mrst_pre_res",   o_res, 64'h2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("mrst_valid",    {63'h0, o_valid}, 64'h0);
    check("mrst_res",      o_res, 64'h0);
    check("mrst_dest",     {60'h0, o_dest}, 64'h0);
    check("mrst_zero",     {63'h0, o_zero}, 64'h0);
    check("mrst_ovf",      {63'h0, o_ovf}, 64'h0);
    check("mrst_busy",     {63'h0, o_busy}, 64'h0);
    check("mrst_in_ready", {63'h0, o_in_ready}, 64'h1);

    // 64-bit, 3-stage instance.
    sel64 = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    cur.delete();
    cur.push_back(mk(ALU_SLL,  64'h1, 64'd63, 4'd5, 64'h8000_0000_0000_0000, 0, 0));
    cur.push_back(mk(ALU_AP4,  64'hFFFF_FFFF_FFFF_FFFC, 64'h0, 4'd6, 64'h0, 1, 0));
    cur.push_back(mk(ALU_SUB,  64'h8000_0000_0000_0000, 64'h1, 4'd7,
                     64'h7FFF_FFFF_FFFF_FFFF, 0, 1));
    cur.push_back(mk(ALU_SRA,  64'h8000_0000_0000_0000, 64'h44, 4'd8,
                     64'hF800_0000_0000_0000, 0, 0));
    cur.push_back(mk(ALU_SLTU, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 4'd9, 64'h0, 1, 0));
    cur.push_back(mk(ALU_ADD,  64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 4'd10,
                     64'h8000_0000_0000_0000, 0, 1));
    stream("t64", 0, 1'b1, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
